// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory access controller:
//   DATA_W        memory / request data width
//   READ_LAT_MAX  largest supported read latency
//   CNT_W         width of the read-latency counter (counts 0..READ_LAT_MAX-1)
//   state_t       controller FSM state encoding
package mem_ctrl_pkg;

   localparam int DATA_W       = 16;
   localparam int READ_LAT_MAX = 4;
   localparam int CNT_W        = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational load-data formatter.
// Ports:
//   d_in      raw 16-bit memory read word
//   is_byte   1 = byte load, 0 = word load (word passes through unchanged)
//   hi_lane   byte address bit 0: selects the upper byte when 1
//   is_signed 1 = sign-extend the selected byte, 0 = zero-extend
//   d_out     formatted load result
module load_align
   import mem_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] d_in,
   input  logic              is_byte,
   input  logic              hi_lane,
   input  logic              is_signed,
   output logic [DATA_W-1:0] d_out
);

   function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic sgn);
      return {{(DATA_W-8){sgn & b[7]}}, b};
   endfunction

   logic [7:0] lane;

   always_comb begin
      lane  = hi_lane ? d_in[15:8] : d_in[7:0];
      d_out = is_byte ? extend_byte(lane, is_signed) : d_in;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Single-outstanding load/store controller between a valid/ready requester
// and a fixed-latency 16-bit memory.
// Parameters:
//   READ_LAT  cycles MemRead is held before d_out is captured (1..4)
//   AW        byte address width
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_write/req_byte/req_signed  store, byte access, sign-extend byte load
//   req_addr, req_wdata            byte address, store data
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_err           load result, misaligned-word error
//   Address, WriteData             memory address / write data
//   MemRead, MemWrite, str_byte    memory strobes and byte-store qualifier
//   d_out                          memory read data
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int READ_LAT = 1,
   parameter int AW       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [AW-1:0]     req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [AW-1:0]     Address,
   output logic [DATA_W-1:0] WriteData,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              str_byte,
   input  logic [DATA_W-1:0] d_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              byte_q, byte_d;
   logic              signed_q, signed_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] aligned;

   load_align u_align (
      .d_in      (d_out),
      .is_byte   (byte_q),
      .hi_lane   (addr_q[0]),
      .is_signed (signed_q),
      .d_out     (aligned)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      byte_d   = byte_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               byte_d   = req_byte;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               cnt_d    = '0;
               // Odd-address word access never touches memory.
               if (!req_byte && req_addr[0]) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = req_write ? ST_WRITE : ST_READ;
               end
            end
         end
         ST_READ: begin
            // Counter clears on exit so it can never run past READ_LAT.
            if (cnt_q == CNT_LAST) begin
               rdata_d = aligned;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode from state only, so reset zeroes them without clearing data flops.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      MemRead    = (state_q == ST_READ);
      MemWrite   = (state_q == ST_WRITE);
      str_byte   = (state_q == ST_WRITE) && byte_q;
      Address    = (MemRead || MemWrite) ? addr_q : '0;
      WriteData  = '0;
      if (state_q == ST_WRITE)
         WriteData = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
      resp_valid = (state_q == ST_RESP);
      resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
      resp_err   = (state_q == ST_RESP) && err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      byte_q   <= byte_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        sel = 1'b0;   // 0 -> READ_LAT=1 instance, 1 -> READ_LAT=3 instance
   logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0, d_out = '0;
   logic        resp_ready = 1'b0;

   logic        vld1, vld3;
   logic        rr1, rv1, re1, mr1, mw1, sb1, rr3, rv3, re3, mr3, mw3, sb3;
   logic [15:0] rd1, ad1, wd1, rd3, ad3, wd3;

   assign vld1 = req_valid & ~sel;
   assign vld3 = req_valid & sel;

   mem_access_ctrl #(.READ_LAT(1), .AW(16)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(vld1), .req_ready(rr1), .req_write(req_write),
      .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1),
      .Address(ad1), .WriteData(wd1), .MemRead(mr1), .MemWrite(mw1), .str_byte(sb1), .d_out(d_out));

   mem_access_ctrl #(.READ_LAT(3), .AW(16)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(vld3), .req_ready(rr3), .req_write(req_write),
      .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(re3),
      .Address(ad3), .WriteData(wd3), .MemRead(mr3), .MemWrite(mw3), .str_byte(sb3), .d_out(d_out));

   logic        req_ready, resp_valid, resp_err, MemRead, MemWrite, str_byte;
   logic [15:0] resp_rdata, Address, WriteData;
   assign req_ready  = sel ? rr3 : rr1;
   assign resp_valid = sel ? rv3 : rv1;
   assign resp_err   = sel ? re3 : re1;
   assign MemRead    = sel ? mr3 : mr1;
   assign MemWrite   = sel ? mw3 : mw1;
   assign str_byte   = sel ? sb3 : sb1;
   assign resp_rdata = sel ? rd3 : rd1;
   assign Address    = sel ? ad3 : ad1;
   assign WriteData  = sel ? wd3 : wd1;

   int total = 0;
   int bad   = 0;

   // Observations from the last transaction.
   int          ob_rd, ob_wr, ob_bad_strobe, ob_lat;
   logic [15:0] ob_addr_rd, ob_addr_wr, ob_wdata, ob_rdata;
   logic        ob_sb, ob_err, ob_addr_moved, ob_bp_unstable, ob_rdy_busy, ob_idle_after;

   // ---------------- reference model ----------------
   function automatic int cur_lat();
      return sel ? 3 : 1;
   endfunction

   function automatic logic is_misaligned(input logic b, input logic [15:0] a);
      return !b && (a % 2 == 1);
   endfunction

   function automatic logic [15:0] exp_rdata(input logic w, b, s, input logic [15:0] a, dv);
      logic [7:0] by;
      if (is_misaligned(b, a) || w) return 16'h0000;
      if (!b) return dv;
      by = (a % 2 == 1) ? dv[15:8] : dv[7:0];
      if (s && by >= 8'h80) return 16'hFF00 + 16'(by);
      return 16'(by);
   endfunction

   function automatic int exp_lat(input logic w, b, input logic [15:0] a);
      if (is_misaligned(b, a)) return 1;
      if (w) return 2;
      return 1 + cur_lat();
   endfunction

   function automatic int exp_nrd(input logic w, b, input logic [15:0] a);
      return (!w && !is_misaligned(b, a)) ? cur_lat() : 0;
   endfunction

   function automatic int exp_nwr(input logic w, b, input logic [15:0] a);
      return (w && !is_misaligned(b, a)) ? 1 : 0;
   endfunction

   // ---------------- transaction driver (records, does not judge) ----------------
   task run_txn(input logic w, b, s, input logic [15:0] a, wd, dv, input int hold);
      logic accepted;
      ob_rd = 0; ob_wr = 0; ob_bad_strobe = 0; ob_lat = -1;
      ob_addr_rd = '0; ob_addr_wr = '0; ob_wdata = '0; ob_rdata = '0;
      ob_sb = 1'b0; ob_err = 1'b0; ob_addr_moved = 1'b0; ob_bp_unstable = 1'b0;
      ob_rdy_busy = 1'b0; ob_idle_after = 1'b0;
      accepted = 1'b0;
      @(negedge clk);
      req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
      d_out = dv; resp_ready = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (req_ready) begin
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      // Scramble request fields so only latched values can produce correct results.
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
      req_byte = 1'($urandom); req_signed = 1'($urandom); req_write = 1'($urandom);
      if (accepted) begin
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (MemRead) begin
               ob_rd++;
               if (ob_rd == 1) ob_addr_rd = Address;
               else if (Address !== ob_addr_rd) ob_addr_moved = 1'b1;
            end
            if (MemWrite) begin
               ob_wr++; ob_addr_wr = Address; ob_wdata = WriteData; ob_sb = str_byte;
            end
            if ((MemRead && MemWrite) || (str_byte && !MemWrite)) ob_bad_strobe++;
            if (req_ready) ob_rdy_busy = 1'b1;
            if (resp_valid) begin
               ob_lat = c; ob_rdata = resp_rdata; ob_err = resp_err;
               break;
            end
         end
      end
      if (ob_lat > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== ob_rdata || resp_err !== ob_err) ob_bp_unstable = 1'b1;
            if (req_ready) ob_rdy_busy = 1'b1;
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         @(negedge clk);
         ob_idle_after = !resp_valid && req_ready;
      end
   endtask

   // ---------------- tests ----------------
   task test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         sel = k[0];
         #1;
         total++;
         if ({req_ready, resp_valid, resp_err, MemRead, MemWrite, str_byte} !== 6'b100000 ||
             resp_rdata !== 16'h0 || Address !== 16'h0 || WriteData !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs[%0d]: ctl=%b rdata=%h addr=%h wdata=%h, want ctl=100000 and zeros",
                     k, {req_ready, resp_valid, resp_err, MemRead, MemWrite, str_byte},
                     resp_rdata, Address, WriteData);
         end
      end
      @(negedge clk);
      sel = 1'b0;
      rst = 1'b1;
   endtask

   task test_store();
      sel = 1'b0;
      run_txn(1'b1, 1'b0, 1'b0, 16'h0004, 16'hABCD, 16'h0000, 0);
      total++;
      if (ob_wr !== 1 || ob_addr_wr !== 16'h0004 || ob_wdata !== 16'hABCD || ob_sb !== 1'b0) begin
         bad++;
         $display("FAIL word_store: nwr=%0d addr=%h wdata=%h sb=%b, want 1 0004 ABCD 0",
                  ob_wr, ob_addr_wr, ob_wdata, ob_sb);
      end
      total++;
      if (ob_lat !== 2 || ob_err !== 1'b0 || ob_rdata !== 16'h0 || ob_rd !== 0) begin
         bad++;
         $display("FAIL word_store_resp: lat=%0d err=%b rdata=%h nrd=%0d, want 2 0 0000 0",
                  ob_lat, ob_err, ob_rdata, ob_rd);
      end
      run_txn(1'b1, 1'b1, 1'b0, 16'h0005, 16'h12EF, 16'h0000, 0);
      total++;
      if (ob_wr !== 1 || ob_addr_wr !== 16'h0005 || ob_wdata !== 16'hEFEF || ob_sb !== 1'b1 || ob_err !== 1'b0) begin
         bad++;
         $display("FAIL byte_store: nwr=%0d addr=%h wdata=%h sb=%b err=%b, want 1 0005 EFEF 1 0",
                  ob_wr, ob_addr_wr, ob_wdata, ob_sb, ob_err);
      end
   endtask

   task test_load();
      logic [15:0] addrs [3];
      logic        sgns  [3];
      logic [15:0] wants [3];
      addrs[0] = 16'h0005; sgns[0] = 1'b1; wants[0] = 16'hFF80;
      addrs[1] = 16'h0004; sgns[1] = 1'b0; wants[1] = 16'h00CD;
      addrs[2] = 16'h0004; sgns[2] = 1'b1; wants[2] = 16'hFFCD;
      sel = 1'b0;
      run_txn(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'hABCD, 0);
      total++;
      if (ob_rd !== 1 || ob_addr_rd !== 16'h0004 || ob_rdata !== 16'hABCD || ob_lat !== 2 || ob_err !== 1'b0) begin
         bad++;
         $display("FAIL word_load: nrd=%0d addr=%h rdata=%h lat=%0d err=%b, want 1 0004 ABCD 2 0",
                  ob_rd, ob_addr_rd, ob_rdata, ob_lat, ob_err);
      end
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, 1'b1, sgns[i], addrs[i], 16'h0000, 16'h80CD, 0);
         total++;
         if (ob_rdata !== wants[i] || ob_rd !== 1 || ob_err !== 1'b0) begin
            bad++;
            $display("FAIL byte_load[%0d]: rdata=%h nrd=%0d err=%b, want %h 1 0",
                     i, ob_rdata, ob_rd, ob_err, wants[i]);
         end
      end
      sel = 1'b1;
      run_txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 0);
      total++;
      if (ob_rd !== 3 || ob_addr_moved !== 1'b0 || ob_rdata !== 16'h1234 || ob_lat !== 4) begin
         bad++;
         $display("FAIL lat3_load: nrd=%0d moved=%b rdata=%h lat=%0d, want 3 0 1234 4",
                  ob_rd, ob_addr_moved, ob_rdata, ob_lat);
      end
      sel = 1'b0;
   endtask

   task test_misaligned();
      sel = 1'b0;
      run_txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hBEEF, 0);
      total++;
      if (ob_err !== 1'b1 || ob_rdata !== 16'h0 || ob_rd !== 0 || ob_wr !== 0 || ob_lat !== 1) begin
         bad++;
         $display("FAIL misaligned_load: err=%b rdata=%h nrd=%0d nwr=%0d lat=%0d, want 1 0000 0 0 1",
                  ob_err, ob_rdata, ob_rd, ob_wr, ob_lat);
      end
      run_txn(1'b1, 1'b0, 1'b0, 16'h0007, 16'h5555, 16'h0000, 0);
      total++;
      if (ob_err !== 1'b1 || ob_wr !== 0 || ob_lat !== 1) begin
         bad++;
         $display("FAIL misaligned_store: err=%b nwr=%0d lat=%0d, want 1 0 1", ob_err, ob_wr, ob_lat);
      end
   endtask

   task test_backpressure();
      sel = 1'b0;
      run_txn(1'b0, 1'b1, 1'b1, 16'h0009, 16'h0000, 16'hC311, 3);
      total++;
      if (ob_bp_unstable !== 1'b0 || ob_rdy_busy !== 1'b0 || ob_rdata !== 16'hFFC3) begin
         bad++;
         $display("FAIL backpressure: unstable=%b ready_busy=%b rdata=%h, want 0 0 FFC3",
                  ob_bp_unstable, ob_rdy_busy, ob_rdata);
      end
      total++;
      if (ob_idle_after !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_release: idle_after=%b want 1", ob_idle_after);
      end
   endtask

   task test_abort();
      int seen;
      sel = 1'b1;
      @(negedge clk);
      req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0010;
      d_out = 16'h7777; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (MemRead !== 1'b1) begin
         bad++;
         $display("FAIL abort_setup: MemRead=%b want 1", MemRead);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (MemRead !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || Address !== 16'h0) begin
         bad++;
         $display("FAIL abort_reset: MemRead=%b resp_valid=%b req_ready=%b addr=%h, want 0 0 1 0000",
                  MemRead, resp_valid, req_ready, Address);
      end
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid || MemRead || !req_ready) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL abort_quiet: %0d active cycles after abort, want 0", seen);
      end
      sel = 1'b0;
   endtask

   task test_random();
      logic        w, b, s;
      logic [15:0] a, wd, dv;
      int          hold;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sel = 1'($urandom);
         w = 1'($urandom); b = 1'($urandom); s = 1'($urandom);
         a = 16'($urandom); wd = 16'($urandom); dv = 16'($urandom);
         hold = $urandom_range(0, 2);
         run_txn(w, b, s, a, wd, dv, hold);
         total++;
         if (ob_lat !== exp_lat(w, b, a) || ob_err !== is_misaligned(b, a) ||
             ob_rdata !== exp_rdata(w, b, s, a, dv)) begin
            bad++;
            $display("FAIL rand_resp[%0d]: lat=%0d err=%b rdata=%h, want %0d %b %h (w=%b b=%b s=%b a=%h d=%h)",
                     i, ob_lat, ob_err, ob_rdata, exp_lat(w, b, a), is_misaligned(b, a),
                     exp_rdata(w, b, s, a, dv), w, b, s, a, dv);
         end
         total++;
         if (ob_rd !== exp_nrd(w, b, a) || ob_wr !== exp_nwr(w, b, a) || ob_bad_strobe !== 0 ||
             (ob_rd > 0 && (ob_addr_rd !== a || ob_addr_moved)) ||
             (ob_wr > 0 && (ob_addr_wr !== a || ob_sb !== b ||
                            ob_wdata !== (b ? {wd[7:0], wd[7:0]} : wd)))) begin
            bad++;
            $display("FAIL rand_mem[%0d]: nrd=%0d nwr=%0d badstb=%0d raddr=%h waddr=%h wdata=%h sb=%b, want nrd=%0d nwr=%0d addr=%h",
                     i, ob_rd, ob_wr, ob_bad_strobe, ob_addr_rd, ob_addr_wr, ob_wdata, ob_sb,
                     exp_nrd(w, b, a), exp_nwr(w, b, a), a);
         end
         total++;
         if (ob_bp_unstable || ob_rdy_busy || !ob_idle_after) begin
            bad++;
            $display("FAIL rand_hs[%0d]: unstable=%b ready_busy=%b idle_after=%b, want 0 0 1",
                     i, ob_bp_unstable, ob_rdy_busy, ob_idle_after);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misaligned();
      test_backpressure();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: READ_LAT, default 1, number of cycles MemRead is held before d_out is sampled (legal range 1-4).
REQ-002 Parameter: AW, default 16, address width; data width fixed at 16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  requester presents a transaction.
REQ-006 req_ready  output  1  controller can accept a transaction.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_byte  input  1  1 = byte access, 0 = word access.
REQ-009 req_signed  input  1  byte loads: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  AW  byte address.
REQ-011 req_wdata  input  16  store data; byte stores use [7:0].
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  requester accepts the response.
REQ-014 resp_rdata  output  16  load result; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned word access; valid with resp_valid.
REQ-016 Address  output  AW  memory address.
REQ-017 WriteData  output  16  memory write data.
REQ-018 MemRead  output  1  memory read enable.
REQ-019 MemWrite  output  1  memory write enable.
REQ-020 str_byte  output  1  byte-store qualifier to memory.
REQ-021 d_out  input  16  memory read data.

Function
REQ-022 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a transaction is accepted on an edge where req_valid and req_ready are both 1, and all req_* fields are latched then.
REQ-024 An accepted word access with req_addr[0]=1 SHALL go directly to RESP with resp_err=1 and SHALL NOT assert MemRead or MemWrite.
REQ-025 Store: IDLE->WRITE; MemWrite=1 for exactly one cycle with Address=latched addr and str_byte=latched byte; then WRITE->RESP.
REQ-026 Byte store SHALL drive WriteData={wdata[7:0],wdata[7:0]}; word store SHALL drive WriteData=wdata.
REQ-027 Load: IDLE->READ; MemRead=1 for exactly READ_LAT cycles with Address stable; d_out is captured at the end of the last READ cycle; then READ->RESP.
REQ-028 Byte load lane SHALL be d_out[7:0] when addr[0]=0 and d_out[15:8] when addr[0]=1, extended per req_signed; a word load returns d_out unchanged.
REQ-029 In RESP, resp_valid=1 with stable resp_rdata and resp_err until resp_ready=1; RESP->IDLE on that edge.
REQ-030 Latency: accept at edge N -> write strobe in cycle N+1 -> resp_valid from cycle N+2; a load's resp_valid begins in cycle N+1+READ_LAT; a misaligned access's resp_valid begins in cycle N+1.
REQ-031 Outside READ/WRITE, MemRead, MemWrite and str_byte SHALL be 0; MemRead and MemWrite SHALL never both be 1.
REQ-032 A new request SHALL NOT be accepted in the cycle resp_valid is consumed (req_ready is 0 in RESP); back-to-back throughput is one transaction per (latency+1) cycles.
REQ-033 The READ_LAT counter SHALL saturate/clear on exit and SHALL never wrap into a longer read.

Reset
REQ-034 On an edge with rst=0: state=IDLE, counter=0, all outputs 0 except req_ready=1, regardless of the current state.
REQ-035 Reset during READ or WRITE SHALL abort without a response; the strobe deasserts at that edge.

Structure
REQ-036 Package mem_ctrl_pkg SHALL hold the state enumeration, the data-width constant and the READ_LAT upper bound.
REQ-037 Byte-lane selection and extension SHALL be one combinational sub-module, load_align.

Verification
REQ-038 Word store: addr=0004, wdata=ABCD -> one cycle with MemWrite=1, Address=0004, WriteData=ABCD, str_byte=0; resp_valid next cycle, err=0.
REQ-039 Word load: addr=0004, d_out=ABCD, READ_LAT=1 -> MemRead for one cycle; resp_rdata=ABCD.
REQ-040 Byte loads with d_out=80CD: addr=0005 signed -> FF80; addr=0004 unsigned -> 00CD; addr=0004 signed -> FFCD.
REQ-041 Byte store: addr=0005, wdata=12EF -> WriteData=EFEF, str_byte=1.
REQ-042 Misaligned word load at 0003 -> resp_err=1, rdata=0000, MemRead never asserted.
REQ-043 Abort and backpressure: rst=0 in the middle of a READ_LAT=3 load -> no resp_valid, outputs zero, req_ready=1; separately, resp_ready held 0 for 3 cycles -> resp_valid and data stay stable for those cycles and req_ready stays 0.
